// File: rtl/cpu_pkg.sv
// Shared types and defaults for the data-memory arbiter.
//   DMEM_ADDR_W / DMEM_DATA_W : default RAM address / data widths
//   arb_state_t               : read-return tracking state
//   arb_owner_t               : which requester owns the RAM port this cycle
package cpu_pkg;

    localparam int DMEM_ADDR_W = 16;
    localparam int DMEM_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CPU_RD = 2'd1,
        EXT_RD = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_EXT  = 2'd2
    } arb_owner_t;

endpackage

// File: rtl/arb_age_counter.sv
// Saturating age counter for the external requester.
// Counts refused cycles from 0 up to MAX and holds there; clr has priority.
// Ports:
//   clk, reset : clock, asynchronous active-low reset
//   inc        : request refused this cycle
//   clr        : request granted or withdrawn
//   at_max     : counter has reached MAX (always 1 when MAX = 0)
module arb_age_counter #(
    parameter int MAX = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int CW = (MAX < 1) ? 1 : $clog2(MAX + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && (cnt != CW'(MAX)))
            cnt <= cnt + 1'b1;
    end

    assign at_max = (cnt == CW'(MAX));

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-port synchronous data RAM between the CPU
// memory stage and an external (debug/loader/DMA) requester.
// One access per cycle; CPU wins unless the external requester has been
// refused EXT_MAX_WAIT cycles. Read data (RAM latency 1) is steered back to
// whichever requester issued the read.
// Ports:
//   clk, reset                      : clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata           : memory-stage request
//   cpu_stall                       : CPU refused this cycle
//   cpu_rdata, cpu_rvalid           : CPU read return
//   ext_req/we/addr/wdata           : external request
//   ext_gnt                         : external access accepted this cycle
//   ext_rdata, ext_rvalid           : external read return
//   ram_address, ram_data, ram_wren : RAM port
//   ram_q                           : RAM registered read data
// Optional build macro DMEM_ARB_PERF_EN adds perf_cpu_stall_cycles and
// perf_ext_grants (32-bit wrapping event counters).
module dmem_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W       = DMEM_ADDR_W,
    parameter int DATA_W       = DMEM_DATA_W,
    parameter int EXT_MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              ext_rvalid,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_cpu_stall_cycles,
    output logic [31:0]       perf_ext_grants
`endif
);

    arb_owner_t        owner;
    arb_state_t        state;
    logic              cpu_grant, ext_grant, at_max;
    logic [ADDR_W-1:0] last_addr;
    logic [DATA_W-1:0] cpu_rdata_q, ext_rdata_q;

    // Grants are forced off while reset is asserted so no access or
    // handshake leaks out during reset.
    always_comb begin
        owner = OWN_NONE;
        if (reset) begin
            if (ext_req && (!cpu_req || at_max))
                owner = OWN_EXT;
            else if (cpu_req)
                owner = OWN_CPU;
        end
    end

    assign cpu_grant = (owner == OWN_CPU);
    assign ext_grant = (owner == OWN_EXT);
    assign cpu_stall = cpu_req & reset & ~cpu_grant;
    assign ext_gnt   = ext_grant;

    arb_age_counter #(.MAX(EXT_MAX_WAIT)) u_age (
        .clk    (clk),
        .reset  (reset),
        .inc    (ext_req & ~ext_grant),
        .clr    (ext_grant | ~ext_req),
        .at_max (at_max)
    );

    // RAM port mux; idle cycles replay the last granted address with the
    // write enable low so the RAM sees no new access.
    always_comb begin
        ram_address = last_addr;
        ram_data    = cpu_wdata;
        ram_wren    = 1'b0;
        case (owner)
            OWN_CPU: begin
                ram_address = cpu_addr;
                ram_data    = cpu_wdata;
                ram_wren    = cpu_we;
            end
            OWN_EXT: begin
                ram_address = ext_addr;
                ram_data    = ext_wdata;
                ram_wren    = ext_we;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            last_addr <= '0;
        else if (owner != OWN_NONE)
            last_addr <= ram_address;
    end

    // Read-return tracker. The state says whose read is on ram_q this
    // cycle; the rdata hold registers keep the last returned word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cpu_rvalid  <= 1'b0;
            ext_rvalid  <= 1'b0;
            cpu_rdata_q <= '0;
            ext_rdata_q <= '0;
        end else begin
            if (state == CPU_RD) cpu_rdata_q <= ram_q;
            if (state == EXT_RD) ext_rdata_q <= ram_q;
            cpu_rvalid <= cpu_grant & ~cpu_we;
            ext_rvalid <= ext_grant & ~ext_we;
            if (cpu_grant && !cpu_we)
                state <= CPU_RD;
            else if (ext_grant && !ext_we)
                state <= EXT_RD;
            else
                state <= IDLE;
        end
    end

    assign cpu_rdata = (state == CPU_RD) ? ram_q : cpu_rdata_q;
    assign ext_rdata = (state == EXT_RD) ? ram_q : ext_rdata_q;

`ifdef DMEM_ARB_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_cpu_stall_cycles <= '0;
            perf_ext_grants       <= '0;
        end else begin
            if (cpu_stall) perf_cpu_stall_cycles <= perf_cpu_stall_cycles + 32'd1;
            if (ext_gnt)   perf_ext_grants       <= perf_ext_grants + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter (EXT_MAX_WAIT = 3) with a
// behavioural one-cycle-latency RAM model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, ext_req, ext_we;
    logic [15:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
    logic        cpu_stall, cpu_rvalid, ext_gnt, ext_rvalid, ram_wren;
    logic [15:0] cpu_rdata, ext_rdata, ram_address, ram_data, ram_q;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_cpu_stall_cycles, perf_ext_grants;
`endif

    logic [15:0] mem [0:65535];
    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wren) mem[ram_address] <= ram_data;
        ram_q <= mem[ram_address];
    end

    dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .EXT_MAX_WAIT(3)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_gnt(ext_gnt), .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
        .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
        .ram_q(ram_q)
`ifdef DMEM_ARB_PERF_EN
        , .perf_cpu_stall_cycles(perf_cpu_stall_cycles), .perf_ext_grants(perf_ext_grants)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
    endtask

    initial begin
        logic exp_stall;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0;
        mem[16'h0010] = 16'hBEEF;
        mem[16'h0001] = 16'h1111;
        mem[16'h0002] = 16'h2222;
        idle_all();
        reset = 1'b0;

        // Reset state with both requesters asking.
        cpu_req = 1'b1; ext_req = 1'b1; ext_we = 1'b1; cpu_addr = 16'h0055; ext_addr = 16'h0066;
        step(); step();
        chk("rst_stall",  cpu_stall,   0);
        chk("rst_gnt",    ext_gnt,     0);
        chk("rst_wren",   ram_wren,    0);
        chk("rst_addr",   ram_address, 0);
        chk("rst_rvalid", {cpu_rvalid, ext_rvalid}, 0);
        chk("rst_rdata",  {cpu_rdata, ext_rdata}, 0);
        idle_all();
        #2 reset = 1'b1;
        step();

        // CPU read only.
        cpu_req = 1'b1; cpu_addr = 16'h0010; #1;
        chk("rd_stall", cpu_stall,   0);
        chk("rd_addr",  ram_address, 16'h0010);
        step(); idle_all(); #1;
        chk("rd_rvalid",  cpu_rvalid, 1);
        chk("rd_rdata",   cpu_rdata,  16'hBEEF);
        chk("rd_ext_rv",  ext_rvalid, 0);
        chk("idle_addr",  ram_address, 16'h0010);
        step();
        chk("rd_rv_drop", cpu_rvalid, 0);
        chk("rd_hold",    cpu_rdata,  16'hBEEF);

        // Ext write, then CPU reads it back.
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 16'h0020; ext_wdata = 16'h1234; #1;
        chk("ew_gnt",  ext_gnt,  1);
        chk("ew_wren", ram_wren, 1);
        chk("ew_addr", ram_address, 16'h0020);
        chk("ew_data", ram_data, 16'h1234);
        step(); idle_all();
        chk("ew_no_rv", ext_rvalid, 0);
        cpu_req = 1'b1; cpu_addr = 16'h0020; #1;
        chk("ew_cpu_stall", cpu_stall, 0);
        step(); idle_all(); #1;
        chk("ew_cpu_rv",   cpu_rvalid, 1);
        chk("ew_cpu_data", cpu_rdata,  16'h1234);
        step();

        // Contention: fresh reset so any perf counters start at 0.
        reset = 1'b0; #2 reset = 1'b1;
        cpu_req = 1'b1; cpu_addr = 16'h0001;
        ext_req = 1'b1; ext_addr = 16'h0002;
        for (int c = 1; c <= 8; c++) begin
            #1;
            exp_stall = (c == 4) || (c == 8);
            chk($sformatf("ct_stall%0d", c), cpu_stall, exp_stall);
            chk($sformatf("ct_gnt%0d", c),   ext_gnt,   exp_stall);
            step();
            chk($sformatf("ct_rv%0d", c), {cpu_rvalid, ext_rvalid}, exp_stall ? 2'b01 : 2'b10);
        end
`ifdef DMEM_ARB_PERF_EN
        chk("perf_stall", perf_cpu_stall_cycles, 2);
        chk("perf_ext",   perf_ext_grants,       2);
`endif
        idle_all();
        step(); step();

        // Back-to-back mixed reads.
        cpu_req = 1'b1; cpu_addr = 16'h0001; #1;
        chk("bb_stall", cpu_stall, 0);
        step(); idle_all();
        ext_req = 1'b1; ext_addr = 16'h0002; #1;
        chk("bb_gnt",   ext_gnt,    1);
        chk("bb_cpurv", {cpu_rvalid, ext_rvalid}, 2'b10);
        chk("bb_cpud",  cpu_rdata,  16'h1111);
        step(); idle_all(); #1;
        chk("bb_extrv", {cpu_rvalid, ext_rvalid}, 2'b01);
        chk("bb_extd",  ext_rdata,  16'h2222);
        step();

        // Reset in the middle of a CPU read.
        cpu_req = 1'b1; cpu_addr = 16'h0010; #1;
        chk("mr_stall0", cpu_stall, 0);
        #2 reset = 1'b0; #1;
        chk("mr_stall_rst", cpu_stall, 0);
        chk("mr_addr_rst",  ram_address, 0);
        step();
        chk("mr_rv",    {cpu_rvalid, ext_rvalid}, 0);
        chk("mr_rdata", {cpu_rdata, ext_rdata}, 0);
        chk("mr_wren",  ram_wren, 0);
        #2 reset = 1'b1; #1;
        chk("mr_served", cpu_stall, 0);
        step(); idle_all(); #1;
        chk("mr_rv2", cpu_rvalid, 1);
        chk("mr_d2",  cpu_rdata,  16'hBEEF);
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data RAM between the CPU memory stage and an external requester (debug/loader/DMA port).
- Sits between the Execute-Memory register outputs and the RAM instance.
- Grants one access per cycle and stalls the pipeline when the CPU loses arbitration.
- Routes one-cycle-latency read data back to the requester that issued the read.

Parameters:
- ADDR_W, 16, RAM address width.
- DATA_W, 16, RAM data width.
- EXT_MAX_WAIT, 8, cycles the external requester may be refused before it is forced to win (0 = external always wins).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- cpu_req  in  1  memory-stage access request.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  address.
- cpu_wdata  in  DATA_W  write data.
- cpu_stall  out  1  CPU request refused this cycle; pipeline must hold.
- cpu_rdata  out  DATA_W  read data.
- cpu_rvalid  out  1  cpu_rdata valid.
- ext_req  in  1  external request.
- ext_we  in  1  1 = write.
- ext_addr  in  ADDR_W  address.
- ext_wdata  in  DATA_W  write data.
- ext_gnt  out  1  external access accepted this cycle.
- ext_rdata  out  DATA_W  read data.
- ext_rvalid  out  1  ext_rdata valid.
- ram_address  out  ADDR_W  to RAM address.
- ram_data  out  DATA_W  to RAM write data.
- ram_wren  out  1  to RAM write enable.
- ram_q  in  DATA_W  RAM registered read data, valid one cycle after the address edge.

Behaviour:
- Grant logic (combinational each cycle):
  - ext wins if ext_req and (!cpu_req or wait_cnt == EXT_MAX_WAIT).
  - Otherwise cpu wins if cpu_req.
- cpu_stall = cpu_req & !cpu_grant.
- ext_gnt = ext_grant.
- RAM port mux (combinational):
  - Granted requester's addr/wdata drive ram_address/ram_data.
  - ram_wren = granted & we.
  - With no grant: ram_wren = 0 and ram_address holds its last granted value (registered copy), so no spurious access occurs.
- Read-return state machine (registered), states IDLE, CPU_RD, EXT_RD:
  - Next state = CPU_RD if cpu granted a read, EXT_RD if ext granted a read, else IDLE.
  - A write grant always goes to IDLE.
- Read-return outputs:
  - In CPU_RD: cpu_rvalid = 1, cpu_rdata = ram_q.
  - In EXT_RD: ext_rvalid = 1, ext_rdata = ram_q.
  - Each rdata output holds its last value when its rvalid is 0.
  - Read latency = 1 cycle after the grant edge. Write latency = the grant edge itself.
- Back-to-back reads: a new grant in the same cycle as the rvalid of the previous read is legal. Throughput is 1 access per cycle.
- wait_cnt, counting from 0 to EXT_MAX_WAIT:
  - +1 when ext_req & !ext_gnt, saturating at EXT_MAX_WAIT.
  - Cleared on ext_gnt or when ext_req = 0.
- Ext handshake: requester holds req/we/addr/wdata stable until the cycle ext_gnt = 1. It may drop req the following cycle or present a new request. Dropping req before grant is legal and clears wait_cnt.
- CPU handshake: the memory-stage register is frozen by cpu_stall, so its request repeats until granted.
- Simultaneous requests:
  - Both present and wait_cnt < EXT_MAX_WAIT: cpu wins, wait_cnt increments.
  - Both present and wait_cnt == EXT_MAX_WAIT: ext wins, cpu_stall = 1, wait_cnt -> 0 next cycle.
- Reset asserted (reset = 0), at any time including mid-read:
  - state = IDLE, wait_cnt = 0, ram_address = 0.
  - cpu_rvalid = ext_rvalid = 0, cpu_rdata = ext_rdata = 0, ram_wren = 0.
  - cpu_stall = 0 and ext_gnt = 0 while in reset.
  - A pending read return is discarded.

Optional Feature:
- DMEM_ARB_PERF_EN defined: adds outputs perf_cpu_stall_cycles [31:0] and perf_ext_grants [31:0].
  - perf_cpu_stall_cycles increments on every cycle with cpu_stall = 1.
  - perf_ext_grants increments on every cycle with ext_gnt = 1.
  - Both wrap at 2^32 and reset to 0.
- Not defined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared package cpu_pkg holds:
  - ADDR_W and DATA_W defaults.
  - enum arb_state_t {IDLE, CPU_RD, EXT_RD}.
  - enum arb_owner_t {OWN_NONE, OWN_CPU, OWN_EXT}.
- One natural sub-module: arb_age_counter, the saturating wait counter with clear. Its inputs are inc and clr, its output is at_max.

Test Plan:
- CPU read only: cpu_req = 1, we = 0, addr = 0x0010, RAM[0x10] = 0xBEEF -> cpu_stall = 0; next cycle cpu_rvalid = 1, cpu_rdata = 0xBEEF; ext_rvalid = 0.
- Ext write then CPU read: ext writes 0x1234 to 0x0020 while cpu idle -> ext_gnt = 1 same cycle; CPU reads 0x0020 next cycle -> cpu_rdata = 0x1234 one cycle later.
- Contention with EXT_MAX_WAIT = 3: cpu_req and ext_req held continuously -> cpu granted 3 cycles (cpu_stall = 0); cycle 4 ext_gnt = 1 and cpu_stall = 1; cycle 5 cpu granted again.
- Back-to-back mixed reads: cpu read 0x0001 at cycle N, ext read 0x0002 at cycle N+1 -> cpu_rvalid at N+1 with RAM[1]; ext_rvalid at N+2 with RAM[2]; never both rvalid in the same cycle.
- Reset mid-read: cpu read granted, reset = 0 before the next edge -> cpu_rvalid stays 0; all outputs at reset values; after reset = 1, first request served normally.
- DMEM_ARB_PERF_EN: run the contention test for 8 cycles -> perf_ext_grants = 2, perf_cpu_stall_cycles = 2.
